// File: rtl/paddle_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : paddle_button_conditioner
// Brief    : Synchronises and debounces two active-low paddle buttons and
//            turns a held button into one-cycle step strobes. The first strobe
//            is immediate, then the strobes auto-repeat. Define PADDLE_ACCEL_EN
//            to build the slow-to-fast repeat acceleration.
// Revision : 1.0 - initial release
// ============================================================================
module paddle_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SLOW_PERIOD     = 500000,
    parameter int FAST_PERIOD     = 150000,
    parameter int ACCEL_STEPS     = 16,
    parameter int CNT_WIDTH       = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] key_n,
    output logic [1:0] button,
    output logic [1:0] held,
    output logic       fast
);

    localparam logic [CNT_WIDTH-1:0] c_DEB_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_SLOW_LAST = CNT_WIDTH'(SLOW_PERIOD - 1);
`ifdef PADDLE_ACCEL_EN
    localparam logic [CNT_WIDTH-1:0] c_FAST_LAST = CNT_WIDTH'(FAST_PERIOD - 1);
    localparam int                   c_STEP_W    = $clog2(ACCEL_STEPS + 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SLOW = 2'd1,
        S_FAST = 2'd2
    } state_t;

    logic [1:0]           r_sync1;
    logic [1:0]           r_sync2;
    logic [1:0]           w_debN;
    logic [1:0]           w_dir;
    logic [CNT_WIDTH-1:0] w_periodLast;
    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_rateCnt;
    logic [1:0]           r_dir;
`ifdef PADDLE_ACCEL_EN
    logic [c_STEP_W-1:0]  r_stepCnt;
    logic                 r_fast;
`endif

    // Sync flops preset to released so reset never looks like a press.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= 2'b11;
            r_sync2 <= 2'b11;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_debounce
        logic                 r_debN;
        logic [CNT_WIDTH-1:0] r_debCnt;

        always_ff @(posedge clock) begin
            if (reset) begin
                r_debN   <= 1'b1;
                r_debCnt <= '0;
            end else if (r_sync2[gi] == r_debN) begin
                r_debCnt <= '0;
            end else if (r_debCnt == c_DEB_LAST) begin
                r_debN   <= ~r_debN;
                r_debCnt <= '0;
            end else begin
                r_debCnt <= r_debCnt + CNT_WIDTH'(1);
            end
        end

        assign w_debN[gi] = r_debN;
    end

    assign held  = ~w_debN;
    // One-hot direction; both or neither held resolves to no movement.
    assign w_dir = (held == 2'b01 || held == 2'b10) ? held : 2'b00;

`ifdef PADDLE_ACCEL_EN
    assign w_periodLast = (r_state == S_FAST) ? c_FAST_LAST : c_SLOW_LAST;
    assign fast         = r_fast;
`else
    assign w_periodLast = c_SLOW_LAST;
    assign fast         = 1'b0;
`endif

    // The FIRST step is taken on the edge that leaves IDLE (or sees a direction
    // reversal), so its strobe lands one cycle after held changes.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_rateCnt <= '0;
            r_dir     <= 2'b00;
            button    <= 2'b11;
`ifdef PADDLE_ACCEL_EN
            r_stepCnt <= '0;
            r_fast    <= 1'b0;
`endif
        end else begin
            button <= 2'b11;
            if (w_dir == 2'b00) begin
                r_state   <= S_IDLE;
                r_rateCnt <= '0;
`ifdef PADDLE_ACCEL_EN
                r_fast    <= 1'b0;
`endif
            end else if (r_state == S_IDLE || w_dir != r_dir) begin
                button    <= ~w_dir;
                r_dir     <= w_dir;
                r_rateCnt <= '0;
`ifdef PADDLE_ACCEL_EN
                r_stepCnt <= c_STEP_W'(1);
                if (ACCEL_STEPS == 1) begin
                    r_state <= S_FAST;
                    r_fast  <= 1'b1;
                end else begin
                    r_state <= S_SLOW;
                    r_fast  <= 1'b0;
                end
`else
                r_state   <= S_SLOW;
`endif
            end else if (r_rateCnt == w_periodLast) begin
                button    <= ~r_dir;
                r_rateCnt <= '0;
`ifdef PADDLE_ACCEL_EN
                // Step count only advances in SLOW, so it saturates at ACCEL_STEPS.
                if (r_state == S_SLOW) begin
                    r_stepCnt <= r_stepCnt + c_STEP_W'(1);
                    if (int'(r_stepCnt) + 1 >= ACCEL_STEPS) begin
                        r_state <= S_FAST;
                        r_fast  <= 1'b1;
                    end
                end
`endif
            end else begin
                r_rateCnt <= r_rateCnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_paddle_button_conditioner.sv
`default_nettype none
// Testbench for paddle_button_conditioner: directed segment table, hand-written
// timing sequences and random presses against a cycle-indexed reference model.
module tb_paddle_button_conditioner;

    localparam int DEB   = 4;
    localparam int SLOWP = 10;
    localparam int FASTP = 3;
    localparam int ACC   = 2;
`ifdef PADDLE_ACCEL_EN
    localparam bit ACCEL = 1'b1;
`else
    localparam bit ACCEL = 1'b0;
`endif
    localparam int MAXC = 4096;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] key_n = 2'b11;
    logic [1:0] button;
    logic [1:0] held;
    logic       fast;

    paddle_button_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .SLOW_PERIOD    (SLOWP),
        .FAST_PERIOD    (FASTP),
        .ACCEL_STEPS    (ACC),
        .CNT_WIDTH      (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .key_n (key_n),
        .button(button),
        .held  (held),
        .fast  (fast)
    );

    always #5 clock = ~clock;

    int nCmp = 0;
    int nBad = 0;
    int cyc  = 0;

    // Histories indexed by clock edge number.
    logic       inR   [MAXC];
    logic [1:0] inK   [MAXC];
    logic [1:0] s2h   [MAXC];
    logic [1:0] debh  [MAXC];
    logic [1:0] heldh [MAXC];
    logic [1:0] expB;
    logic       expF;

    typedef struct {
        logic       rst;
        logic [1:0] key;
        int         cycles;
        logic [1:0] eButton;
        logic [1:0] eHeld;
        logic       eFast;
    } seg_t;

    seg_t segs [13];

    function automatic logic [1:0] dirOf(input logic [1:0] h);
        return (h == 2'b01 || h == 2'b10) ? h : 2'b00;
    endfunction

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: button/held/fast got %b required %b", name, act, exp);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        nCmp++;
        if (act != exp) begin
            nBad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Expected outputs after edge e: a bit flips once DEB consecutive synchronised
    // samples disagree with it; strobes follow the press-relative schedule.
    task automatic modelCycle(input int e);
        logic [1:0] d;
        int  t0;
        int  dd;
        int  span;
        bit  ok;
        bit  strobe;
        s2h[e] = (inR[e] || inR[e-1]) ? 2'b11 : inK[e-1];
        if (inR[e]) begin
            debh[e] = 2'b11;
        end else begin
            debh[e] = debh[e-1];
            for (int b = 0; b < 2; b++) begin
                ok = (e > DEB);
                for (int j = 1; j <= DEB && ok; j++)
                    if (s2h[e-j][b] == debh[e-1][b]) ok = 1'b0;
                for (int j = 1; j < DEB && ok; j++)
                    if (inR[e-j]) ok = 1'b0;
                if (ok) debh[e][b] = ~debh[e-1][b];
            end
        end
        heldh[e] = ~debh[e];
        expB = 2'b11;
        expF = 1'b0;
        d = dirOf(heldh[e-1]);
        if (!inR[e] && d != 2'b00) begin
            t0 = e - 1;
            while (t0 > 0 && dirOf(heldh[t0-1]) == d) t0--;
            dd   = e - 1 - t0;
            span = (ACC - 1) * SLOWP;
            if (!ACCEL)          strobe = (dd % SLOWP == 0);
            else if (dd <= span) strobe = (dd % SLOWP == 0);
            else                 strobe = ((dd - span) % FASTP == 0);
            expF = ACCEL && (dd >= span);
            if (strobe) expB = ~d;
        end
    endtask

    task automatic step(input logic r, input logic [1:0] k);
        reset = r;
        key_n = k;
        @(posedge clock);
        if (cyc >= MAXC - 1) begin
            $display("FAIL historyDepth: got cycle %0d required below %0d", cyc, MAXC - 1);
            $fatal(1, "history depth exceeded");
        end
        cyc++;
        inR[cyc] = r;
        inK[cyc] = k;
        #1;
        modelCycle(cyc);
        check($sformatf("cycle%0d", cyc), {button, held, fast}, {expB, heldh[cyc], expF});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit required $finish first");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rel[$];
        int expRel[4];
        int fastAt;
        int resumeAt;
        int len;
        logic [1:0] k;

        inR[0] = 1'b1; inK[0] = 2'b11; s2h[0] = 2'b11; debh[0] = 2'b11; heldh[0] = 2'b00;

        segs = '{
            '{1'b1, 2'b00,  3, 2'b11, 2'b00, 1'b0},  // reset with both keys down
            '{1'b0, 2'b00,  5, 2'b11, 2'b00, 1'b0},
            '{1'b0, 2'b00,  1, 2'b11, 2'b11, 1'b0},  // held appears 6 after release
            '{1'b0, 2'b00,  2, 2'b11, 2'b11, 1'b0},
            '{1'b0, 2'b11,  8, 2'b11, 2'b00, 1'b0},
            '{1'b0, 2'b01,  3, 2'b11, 2'b00, 1'b0},  // 3-cycle glitch on up
            '{1'b0, 2'b11, 10, 2'b11, 2'b00, 1'b0},
            '{1'b0, 2'b10,  6, 2'b11, 2'b01, 1'b0},  // down press
            '{1'b0, 2'b10,  1, 2'b10, 2'b01, 1'b0},
            '{1'b0, 2'b10,  1, 2'b11, 2'b01, 1'b0},
            '{1'b0, 2'b00, 12, 2'b11, 2'b11, 1'b0},  // both held, no strobes
            '{1'b0, 2'b01,  7, 2'b01, 2'b10, 1'b0},  // release down, up strobe
            '{1'b0, 2'b11, 10, 2'b11, 2'b00, 1'b0}
        };

        for (int s = 0; s < 13; s++) begin
            for (int i = 0; i < segs[s].cycles; i++) step(segs[s].rst, segs[s].key);
            check($sformatf("seg%0d", s), {button, held, fast},
                  {segs[s].eButton, segs[s].eHeld, segs[s].eFast});
        end

        // Hold down: strobe schedule relative to the press.
        if (ACCEL) expRel = '{7, 17, 20, 23};
        else       expRel = '{7, 17, 27, 37};
        rel.delete();
        fastAt = -1;
        for (int i = 1; i <= 40; i++) begin
            step(1'b0, 2'b10);
            if (button != 2'b11) rel.push_back(i);
            if (fast && fastAt < 0) fastAt = i;
        end
        for (int i = 0; i < 4; i++)
            checkInt($sformatf("downStrobe%0d", i), (i < rel.size()) ? rel[i] : -1, expRel[i]);
        checkInt("fastOnset", fastAt, ACCEL ? 17 : -1);
        for (int i = 0; i < 10; i++) step(1'b0, 2'b11);

        // Hold up, reset between strobes, then a fresh debounce.
        for (int i = 1; i <= 21; i++) step(1'b0, 2'b01);
        checkInt("fastBeforeReset", int'(fast), int'(ACCEL));
        step(1'b1, 2'b01);
        check("resetMidRepeat", {button, held, fast}, 5'b11_00_0);
        resumeAt = -1;
        for (int i = 1; i <= 20 && resumeAt < 0; i++) begin
            step(1'b0, 2'b01);
            if (button == 2'b01) resumeAt = i;
        end
        checkInt("resumeStrobe", resumeAt, 7);
        for (int i = 0; i < 10; i++) step(1'b0, 2'b11);

        // Random presses, holds and occasional resets.
        for (int s = 0; s < 60; s++) begin
            k   = 2'($urandom_range(0, 3));
            len = $urandom_range(1, 30);
            if ($urandom_range(0, 19) == 0)
                for (int i = 0; i < int'($urandom_range(1, 2)); i++) step(1'b1, k);
            for (int i = 0; i < len; i++) step(1'b0, k);
        end
        for (int i = 0; i < 12; i++) step(1'b0, 2'b11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
`default_nettype wire
